// File: rtl/key_event.sv
// key_event: turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events behind a one-entry valid/ready register
module key_event #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  input  logic       ev_ready,
  input  logic       clr_overflow,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic       held,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, PRESSED, HOLD} state_t;
  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_q, emit, accept, drop;
  logic [1:0]       code;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    emit    = 1'b0;
    code    = EV_PRESS;
    if (state == IDLE) begin
      if (level && !level_q) begin
        emit    = 1'b1;
        state_n = PRESSED;
        cnt_n   = '0;
      end
    end else if (!level) begin
      emit    = 1'b1;
      code    = EV_RELEASE;
      state_n = IDLE;
    end else if (state == PRESSED) begin
      if (cnt == LONG_LAST) begin
        emit    = 1'b1;
        code    = EV_LONG;
        state_n = HOLD;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else if (REPEAT_EN && cnt == REP_LAST) begin
      emit  = 1'b1;
      code  = EV_REPEAT;
      cnt_n = '0;
    end else begin
      cnt_n = &cnt ? cnt : cnt + 1'b1;
    end
  end
  // a pending unaccepted event blocks the new one; the FSM keeps running
  assign accept = emit & (~ev_valid | ev_ready);
  assign drop   = emit & ev_valid & ~ev_ready;
  assign held   = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      level_q  <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= EV_PRESS;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      level_q  <= level;
      ev_valid <= accept | (ev_valid & ~ev_ready);
      ev_code  <= accept ? code : ev_code;
      overflow <= drop | (overflow & ~clr_overflow);
    end
  end
endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumer side of the push-button input path. Takes an already-debounced, clock-synchronous button level and converts it into discrete key events: PRESS, RELEASE, LONG (hold threshold reached) and REPEAT (auto-repeat while held).
- Events leave through a one-entry valid/ready output register, so the UI/menu logic can accept them at its own pace.
- Sits directly after the debouncer, one instance per button.

Parameters:
- LONG_CYCLES, 50_000_000: cycles the button must stay held after PRESS before LONG fires (1 s at 50 MHz). Must be >= 2.
- REPEAT_CYCLES, 10_000_000: cycles between REPEAT events once LONG has fired. Must be >= 1.
- REPEAT_EN, 1: 1 enables REPEAT events; 0 means no REPEAT events are ever generated.
- CNT_W, 26: hold-counter width. Must satisfy 2^CNT_W >= max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- level  in  1  debounced button level, 1 = pressed, synchronous to clk
- ev_ready  in  1  consumer accepts the current event
- clr_overflow  in  1  one-cycle pulse that clears overflow
- ev_valid  out  1  event register holds a valid event
- ev_code  out  2  event code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
- held  out  1  1 while state is not IDLE
- overflow  out  1  sticky flag: an event was dropped

Behaviour:

Reset:
- Effective on a rising clk edge with reset=1.
- Resets: state=IDLE, hold counter=0, level_q=0, ev_valid=0, ev_code=0, overflow=0; held=0.
- Reset takes priority over all other activity, including mid-hold and with an event pending. The pending event is discarded.
- Because level_q resets to 0, a button still held when reset deasserts produces a PRESS on the first post-reset edge.

Edge detection:
- level_q is level registered each cycle.
- rise = level & ~level_q.

State machine (all transitions on the clk edge):
- IDLE:
  - On rise: emit PRESS, counter<=0, go to PRESSED.
  - Otherwise stay in IDLE.
- PRESSED:
  - If level=0: emit RELEASE, go to IDLE.
  - Else if counter==LONG_CYCLES-1: emit LONG, counter<=0, go to HOLD.
  - Else counter<=counter+1.
  - LONG therefore fires on the LONG_CYCLES-th edge after the PRESS edge.
- HOLD:
  - If level=0: emit RELEASE, go to IDLE.
  - Else if REPEAT_EN and counter==REPEAT_CYCLES-1: emit REPEAT, counter<=0.
  - Else counter<=counter+1, saturating at all-ones.
- Release has priority over LONG/REPEAT when both apply on the same edge.
- held is combinational from state: (state != IDLE).

Output register and handshake:
- An event is emitted at most once per edge. Emitting loads ev_code and sets ev_valid on that same edge: registered latency of 1 edge from the sampled level.
- ev_valid and ev_code hold stable until an edge where ev_valid & ev_ready.
- On an edge with ev_valid & ev_ready and no new event: ev_valid<=0.
- On an edge with ev_valid & ev_ready and a new event: the new event loads, ev_valid stays 1, no bubble.
- On an edge with ev_valid & ~ev_ready and a new event:
  - The new event is dropped.
  - The held event is unchanged.
  - overflow<=1.
  - The state machine advances regardless; events never stall it.
- ev_ready is ignored while ev_valid=0.
- overflow clears on clr_overflow=1 unless a drop occurs on the same edge, in which case set wins.

Counter:
- Unsigned, CNT_W bits, no wrap in any state.

Test Plan:
1. LONG=8, REPEAT=4, ready=1. level=1 sampled on edges 0-2, 0 on edge 3 -> PRESS valid after edge 0, RELEASE after edge 3. No LONG, held=0 after edge 3.
2. Same params, level=1 sampled on edges 0-16, 0 on edge 17 -> PRESS@0, LONG@8, REPEAT@12, REPEAT@16, RELEASE@17. overflow=0.
3. Boundary: level=1 on edges 0-7, 0 on edge 8 -> RELEASE@8 and no LONG. Repeat the run with REPEAT_EN=0 and a 17-edge hold -> PRESS@0, LONG@8, RELEASE@17, no REPEAT.
4. ready=0 throughout: PRESS@0, release@3 -> ev_code stays 0 with ev_valid=1, overflow=1. Then ready=1 for one edge -> ev_valid=0. Then clr_overflow -> overflow=0. Also: ev_valid=1, ready=1 on the same edge as a RELEASE -> ev_code=1, ev_valid stays 1, no drop.
5. Reset mid-HOLD with an event pending -> after reset ev_valid=0, held=0, overflow=0. With level still 1, the first post-reset edge gives PRESS; LONG follows 8 edges later.
